exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
Parametrised successor to the pipeline's exception detector for the multicycle-free MIPS core. Detects decode faults (illegal opcode, illegal funct, out-of-range register) in ID, ALU overflow in EX, and an external interrupt. It arbitrates by pipeline age, captures cause and EPC, and drives flush and PC-redirect for a handler. It holds the exception until software acknowledges it and queues one pending exception behind the active one.

Parameters:
PC_WIDTH, 6, width of PC values and handler vector
REG_DIR_WIDTH, 3, implemented register-address bits; addresses with any of bits [4:REG_DIR_WIDTH] set are illegal (check disabled when 5)
HANDLER_PC, 6'd60, PC loaded on redirect
CNT_WIDTH, 8, width of saturating exception counter
IRQ_EN, 1, 1 enables the irq source

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
ifid_valid  in  1  ID stage holds a real instruction (not bubble/flushed)
opcode  in  6  ID instruction [31:26]
funct  in  6  ID instruction [5:0]
rs, rt, rd  in  5 each  ID register fields
ifid_pc  in  PC_WIDTH  PC of ID instruction
idex_valid  in  1  EX stage holds a real instruction
ov  in  1  ALU overflow from EX
idex_pc  in  PC_WIDTH  PC of EX instruction
irq  in  1  level external interrupt
cause_mask  in  5  per-cause enable, bit k-1 = cause k; masked causes are ignored
ack  in  1  one-cycle pulse, handler done (eret)
exc_valid  out  1  an exception is active
exc_cause  out  3  0 none, 1 opcode, 2 funct, 3 reg addr, 4 overflow, 5 irq
exc_pc  out  PC_WIDTH  EPC of active exception
flush_ifid, flush_idex, flush_exmem  out  1 each  single-cycle flush strobes
pc_redirect  out  1  single-cycle; PC mux selects HANDLER_PC
handler_pc  out  PC_WIDTH  constant HANDLER_PC
exc_count  out  CNT_WIDTH  exceptions taken since reset, saturating

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0 except handler_pc. Pending slot is cleared.
- Legal opcodes are RTYPE 0, LW 35, SW 43, BEQ 4. Legal R funct values are 32, 34, 36, 37, 42. An all-zero instruction (opcode=funct=rs=rt=rd=0) is a NOP and is legal.
- Register check: R-type checks rs, rt, rd. LW/SW/BEQ check rs, rt only.
- Detection is qualified by the stage valid bit and by cause_mask.
- Candidate priority per cycle: overflow (EX, older) > opcode > funct > reg > irq. Only one candidate is selected.
- FSM states: IDLE, FLUSH, HANDLE.
- IDLE, candidate present: next edge latches exc_cause and exc_pc (idex_pc for cause 4; ifid_pc for causes 1–3; ifid_pc for irq, so the ID instruction re-executes). Also sets exc_valid=1, increments exc_count, and goes to FLUSH. Latency from detect to registered output is 1 cycle.
- FLUSH, one cycle: pc_redirect=1 and flush_ifid=flush_idex=1. flush_exmem=1 only when the cause is 4. Then go to HANDLE.
- During FLUSH, inputs are ignored because the flushed stages are invalid.
- HANDLE: exc_valid, exc_cause and exc_pc are held stable. A new unmasked candidate is written into the single pending slot. A higher-priority candidate overwrites the slot; a lower-priority one is dropped. Flush and redirect stay 0.
- HANDLE + ack, pending empty: go to IDLE and clear exc_valid/exc_cause/exc_pc to 0 on the same edge.
- HANDLE + ack, pending full: load the pending entry into cause/pc, clear the slot, increment the count, and go to FLUSH. exc_valid stays 1 with no gap.
- HANDLE + ack + new candidate in the same cycle: the new candidate is compared against the pending entry by priority. The winner is taken and the loser is dropped.
- ack outside HANDLE is ignored.
- irq is level-sensitive. It re-triggers after ack if still high.
- exc_count saturates at all-ones.
- rst asserted in any state returns to IDLE immediately. Flush/redirect strobes drop asynchronously.

Decomposition:
- Shared package: opcode/funct constants and cause codes (CAUSE_NONE..CAUSE_IRQ) in mips_pkg, shared with the decoder and control unit.
- One sub-module, exc_detect: purely combinational legality check plus priority encoder producing cand_valid, cand_cause, cand_pc.
- FSM, pending slot and counter live in exception_ctrl.

Test Plan:
- Reset with rst=0 mid-HANDLE -> all outputs 0, state IDLE, exc_count=0; release and idle for 5 cycles -> nothing asserts.
- opcode=6'd2, ifid_valid=1, ifid_pc=12 -> next cycle exc_valid=1, cause=1, exc_pc=12; following cycle pc_redirect=flush_ifid=flush_idex=1, flush_exmem=0; count=1.
- ov=1, idex_pc=8 and funct=6'd7 (R-type) with ifid_pc=9 in the same cycle -> cause=4, exc_pc=8, flush_exmem=1. Funct fault dropped (flushed).
- In HANDLE: rs=5'd9 (REG_DIR_WIDTH=3) then irq=1 -> pending holds cause 3. ack -> cause=3 loaded, FLUSH repeats, exc_valid stays 1, count increments.
- cause_mask=5'b11110 with opcode=6'd2 -> no exception. All-zero NOP with ifid_valid=1 -> no exception.
- 260 overflows with CNT_WIDTH=8 -> exc_count stops at 255.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and exception cause codes.
package mips_pkg;

  // Legal primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // Legal R-type funct values
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_OPCODE = 3'd1,
    CAUSE_FUNCT  = 3'd2,
    CAUSE_REG    = 3'd3,
    CAUSE_OV     = 3'd4,
    CAUSE_IRQ    = 3'd5
  } cause_e;

  // Arbitration rank: larger wins. Overflow is oldest in the pipe.
  function automatic logic [2:0] cause_rank(input cause_e c);
    case (c)
      CAUSE_OV:     return 3'd5;
      CAUSE_OPCODE: return 3'd4;
      CAUSE_FUNCT:  return 3'd3;
      CAUSE_REG:    return 3'd2;
      CAUSE_IRQ:    return 3'd1;
      default:      return 3'd0;
    endcase
  endfunction

  // Register address uses bits beyond the implemented register file
  function automatic logic reg_out_of_range(input logic [4:0] r, input int unsigned w);
    if (w >= 32'd5) return 1'b0;
    return (r >> w) != 5'd0;
  endfunction

endpackage

// File: rtl/exc_detect.sv
// Combinational fault detection and age-priority selection of one candidate.
module exc_detect
  import mips_pkg::*;
#(
  parameter int unsigned PC_WIDTH      = 6,
  parameter int unsigned REG_DIR_WIDTH = 3,
  parameter bit          IRQ_EN        = 1'b1
) (
  input  logic                ifid_valid_i,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  input  logic [4:0]          rs_i,
  input  logic [4:0]          rt_i,
  input  logic [4:0]          rd_i,
  input  logic [PC_WIDTH-1:0] ifid_pc_i,
  input  logic                idex_valid_i,
  input  logic                ov_i,
  input  logic [PC_WIDTH-1:0] idex_pc_i,
  input  logic                irq_i,
  input  logic [4:0]          cause_mask_i,
  output logic                cand_valid_o,
  output cause_e              cand_cause_o,
  output logic [PC_WIDTH-1:0] cand_pc_o
);

  logic is_nop, is_r, is_mem;
  logic op_bad, funct_bad, reg_bad, funct_ok;

  // Legality checks on the ID instruction
  always_comb begin
    is_nop   = ~|{opcode_i, funct_i, rs_i, rt_i, rd_i};
    is_r     = (opcode_i == OP_RTYPE);
    is_mem   = (opcode_i == OP_LW) || (opcode_i == OP_SW) || (opcode_i == OP_BEQ);
    op_bad   = !(is_r || is_mem);
    funct_ok = (funct_i == FN_ADD) || (funct_i == FN_SUB) || (funct_i == FN_AND) ||
               (funct_i == FN_OR)  || (funct_i == FN_SLT);
    funct_bad = is_r && !is_nop && !funct_ok;
    reg_bad   = (is_r && (reg_out_of_range(rs_i, REG_DIR_WIDTH) ||
                          reg_out_of_range(rt_i, REG_DIR_WIDTH) ||
                          reg_out_of_range(rd_i, REG_DIR_WIDTH))) ||
                (is_mem && (reg_out_of_range(rs_i, REG_DIR_WIDTH) ||
                            reg_out_of_range(rt_i, REG_DIR_WIDTH)));
  end

  // Priority encoder: EX overflow > opcode > funct > reg > irq
  always_comb begin
    cand_valid_o = 1'b0;
    cand_cause_o = CAUSE_NONE;
    cand_pc_o    = '0;
    if (idex_valid_i && ov_i && cause_mask_i[3]) begin
      cand_valid_o = 1'b1;
      cand_cause_o = CAUSE_OV;
      cand_pc_o    = idex_pc_i;
    end else if (ifid_valid_i && op_bad && cause_mask_i[0]) begin
      cand_valid_o = 1'b1;
      cand_cause_o = CAUSE_OPCODE;
      cand_pc_o    = ifid_pc_i;
    end else if (ifid_valid_i && funct_bad && cause_mask_i[1]) begin
      cand_valid_o = 1'b1;
      cand_cause_o = CAUSE_FUNCT;
      cand_pc_o    = ifid_pc_i;
    end else if (ifid_valid_i && reg_bad && cause_mask_i[2]) begin
      cand_valid_o = 1'b1;
      cand_cause_o = CAUSE_REG;
      cand_pc_o    = ifid_pc_i;
    end else if (IRQ_EN && irq_i && cause_mask_i[4]) begin
      // EPC is the ID instruction so it re-executes after the handler
      cand_valid_o = 1'b1;
      cand_cause_o = CAUSE_IRQ;
      cand_pc_o    = ifid_pc_i;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: FSM, one-deep pending slot and saturating count.
module exception_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned         PC_WIDTH      = 6,
  parameter int unsigned         REG_DIR_WIDTH = 3,
  parameter logic [PC_WIDTH-1:0] HANDLER_PC    = 6'd60,
  parameter int unsigned         CNT_WIDTH     = 8,
  parameter bit                  IRQ_EN        = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ifid_valid,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic [4:0]           rs,
  input  logic [4:0]           rt,
  input  logic [4:0]           rd,
  input  logic [PC_WIDTH-1:0]  ifid_pc,
  input  logic                 idex_valid,
  input  logic                 ov,
  input  logic [PC_WIDTH-1:0]  idex_pc,
  input  logic                 irq,
  input  logic [4:0]           cause_mask,
  input  logic                 ack,
  output logic                 exc_valid,
  output logic [2:0]           exc_cause,
  output logic [PC_WIDTH-1:0]  exc_pc,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 flush_exmem,
  output logic                 pc_redirect,
  output logic [PC_WIDTH-1:0]  handler_pc,
  output logic [CNT_WIDTH-1:0] exc_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    HANDLE = 2'd2
  } state_e;

  state_e               state_q;
  logic                 valid_q;
  cause_e               cause_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic                 pend_valid_q;
  cause_e               pend_cause_q;
  logic [PC_WIDTH-1:0]  pend_pc_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 strobe_q;
  logic                 exmem_q;

  logic                cand_valid;
  cause_e              cand_cause;
  logic [PC_WIDTH-1:0] cand_pc;
  logic                cand_beats_pend;

  exc_detect #(
    .PC_WIDTH      (PC_WIDTH),
    .REG_DIR_WIDTH (REG_DIR_WIDTH),
    .IRQ_EN        (IRQ_EN)
  ) u_detect (
    .ifid_valid_i (ifid_valid),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .rs_i         (rs),
    .rt_i         (rt),
    .rd_i         (rd),
    .ifid_pc_i    (ifid_pc),
    .idex_valid_i (idex_valid),
    .ov_i         (ov),
    .idex_pc_i    (idex_pc),
    .irq_i        (irq),
    .cause_mask_i (cause_mask),
    .cand_valid_o (cand_valid),
    .cand_cause_o (cand_cause),
    .cand_pc_o    (cand_pc)
  );

  // Saturating next count and candidate-vs-pending arbitration
  always_comb begin
    count_d = (&count_q) ? count_q : count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    cand_beats_pend = cand_valid &&
                      (!pend_valid_q || (cause_rank(cand_cause) > cause_rank(pend_cause_q)));
  end

  // Exception FSM with registered outputs, pending slot and counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
      pc_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_cause_q <= CAUSE_NONE;
      pend_pc_q    <= '0;
      count_q      <= '0;
      strobe_q     <= 1'b0;
      exmem_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      exmem_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cand_valid) begin
            valid_q <= 1'b1;
            cause_q <= cand_cause;
            pc_q    <= cand_pc;
            count_q <= count_d;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // Strobes are registered, so they appear the cycle after FLUSH
          strobe_q <= 1'b1;
          exmem_q  <= (cause_q == CAUSE_OV);
          state_q  <= HANDLE;
        end
        HANDLE: begin
          // While strobes are high the ID/EX contents are being discarded,
          // so nothing seen in that cycle may be captured.
          if (strobe_q) begin
            state_q <= HANDLE;
          end else if (ack) begin
            if (pend_valid_q || cand_valid) begin
              if (cand_beats_pend) begin
                cause_q <= cand_cause;
                pc_q    <= cand_pc;
              end else begin
                cause_q <= pend_cause_q;
                pc_q    <= pend_pc_q;
              end
              pend_valid_q <= 1'b0;
              pend_cause_q <= CAUSE_NONE;
              pend_pc_q    <= '0;
              count_q      <= count_d;
              state_q      <= FLUSH;
            end else begin
              valid_q <= 1'b0;
              cause_q <= CAUSE_NONE;
              pc_q    <= '0;
              state_q <= IDLE;
            end
          end else if (cand_beats_pend) begin
            pend_valid_q <= 1'b1;
            pend_cause_q <= cand_cause;
            pend_pc_q    <= cand_pc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exc_valid   = valid_q;
  assign exc_cause   = cause_q;
  assign exc_pc      = pc_q;
  assign flush_ifid  = strobe_q;
  assign flush_idex  = strobe_q;
  assign pc_redirect = strobe_q;
  assign flush_exmem = exmem_q;
  assign handler_pc  = HANDLER_PC;
  assign exc_count   = count_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl.
module tb_exception_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ifid_valid, idex_valid, ov, irq, ack;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, cause_mask;
  logic [5:0] ifid_pc, idex_pc;
  logic       exc_valid, flush_ifid, flush_idex, flush_exmem, pc_redirect;
  logic [2:0] exc_cause;
  logic [5:0] exc_pc, handler_pc;
  logic [7:0] exc_count;

  int errors = 0;
  int checks = 0;

  exception_ctrl #(
    .PC_WIDTH      (6),
    .REG_DIR_WIDTH (3),
    .HANDLER_PC    (6'd60),
    .CNT_WIDTH     (8),
    .IRQ_EN        (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifid_valid  (ifid_valid),
    .opcode      (opcode),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .ifid_pc     (ifid_pc),
    .idex_valid  (idex_valid),
    .ov          (ov),
    .idex_pc     (idex_pc),
    .irq         (irq),
    .cause_mask  (cause_mask),
    .ack         (ack),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .exc_pc      (exc_pc),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .flush_exmem (flush_exmem),
    .pc_redirect (pc_redirect),
    .handler_pc  (handler_pc),
    .exc_count   (exc_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_valid = 1'b0; idex_valid = 1'b0; ov = 1'b0; irq = 1'b0; ack = 1'b0;
    opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0;
    ifid_pc = '0; idex_pc = '0;
  endtask

  // Pulse ack for one cycle
  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    cause_mask = 5'b11111;
    rst = 1'b0;
    #12;
    checks++;
    if ({exc_valid, exc_cause, exc_pc, flush_ifid, flush_idex, flush_exmem, pc_redirect} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs: got valid=%0b cause=%0d pc=%0d strobes=%b%b%b%b, want all 0",
                         exc_valid, exc_cause, exc_pc, flush_ifid, flush_idex, flush_exmem, pc_redirect);
    end
    checks++;
    if (exc_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", exc_count); end
    checks++;
    if (handler_pc !== 6'd60) begin errors++; $display("FAIL handler_pc: got %0d want 60", handler_pc); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({exc_valid, pc_redirect, flush_ifid} !== 3'b000) begin
        errors++; $display("FAIL idle_quiet[%0d]: got valid=%0b redirect=%0b flush=%0b want 0", i, exc_valid, pc_redirect, flush_ifid);
      end
    end
  endtask

  task automatic test_opcode();
    ifid_valid = 1'b1; opcode = 6'd2; ifid_pc = 6'd12;
    tick();
    clear_inputs();
    checks++;
    if ({exc_valid, exc_cause, exc_pc} !== {1'b1, 3'd1, 6'd12}) begin
      errors++; $display("FAIL opcode_capture: got valid=%0b cause=%0d pc=%0d want 1/1/12", exc_valid, exc_cause, exc_pc);
    end
    checks++;
    if (exc_count !== 8'd1) begin errors++; $display("FAIL opcode_count: got %0d want 1", exc_count); end
    checks++;
    if (pc_redirect !== 1'b0) begin errors++; $display("FAIL opcode_early_redirect: got %0b want 0", pc_redirect); end
    tick();
    checks++;
    if ({pc_redirect, flush_ifid, flush_idex, flush_exmem} !== 4'b1110) begin
      errors++; $display("FAIL opcode_flush: got redirect/ifid/idex/exmem=%b%b%b%b want 1110", pc_redirect, flush_ifid, flush_idex, flush_exmem);
    end
    tick();
    checks++;
    if ({pc_redirect, flush_ifid, exc_valid} !== 3'b001) begin
      errors++; $display("FAIL opcode_handle: got redirect=%0b flush=%0b valid=%0b want 0/0/1", pc_redirect, flush_ifid, exc_valid);
    end
    pulse_ack();
    checks++;
    if ({exc_valid, exc_cause, exc_pc} !== 10'd0) begin
      errors++; $display("FAIL opcode_ack_clear: got valid=%0b cause=%0d pc=%0d want 0", exc_valid, exc_cause, exc_pc);
    end
  endtask

  task automatic test_overflow_vs_funct();
    idex_valid = 1'b1; ov = 1'b1; idex_pc = 6'd8;
    ifid_valid = 1'b1; opcode = 6'd0; funct = 6'd7; ifid_pc = 6'd9;
    tick();
    clear_inputs();
    checks++;
    if ({exc_valid, exc_cause, exc_pc} !== {1'b1, 3'd4, 6'd8}) begin
      errors++; $display("FAIL ov_priority: got valid=%0b cause=%0d pc=%0d want 1/4/8", exc_valid, exc_cause, exc_pc);
    end
    tick();
    checks++;
    if ({pc_redirect, flush_ifid, flush_idex, flush_exmem} !== 4'b1111) begin
      errors++; $display("FAIL ov_flush: got redirect/ifid/idex/exmem=%b%b%b%b want 1111", pc_redirect, flush_ifid, flush_idex, flush_exmem);
    end
    tick();
    pulse_ack();
    checks++;
    if (exc_valid !== 1'b0 || exc_count !== 8'd2) begin
      errors++; $display("FAIL ov_done: got valid=%0b count=%0d want 0/2", exc_valid, exc_count);
    end
  endtask

  task automatic test_pending();
    ifid_valid = 1'b1; opcode = 6'd2; ifid_pc = 6'd20;
    tick();
    clear_inputs();
    tick();
    tick();
    // HANDLE: out-of-range rs on an R-type ADD
    ifid_valid = 1'b1; opcode = 6'd0; funct = 6'd32; rs = 5'd9; ifid_pc = 6'd30;
    tick();
    clear_inputs();
    // Lower-priority irq must not displace the pending register fault
    irq = 1'b1; ifid_pc = 6'd31;
    tick();
    clear_inputs();
    checks++;
    if ({exc_valid, exc_cause, exc_pc} !== {1'b1, 3'd1, 6'd20}) begin
      errors++; $display("FAIL pending_hold: got valid=%0b cause=%0d pc=%0d want 1/1/20", exc_valid, exc_cause, exc_pc);
    end
    pulse_ack();
    checks++;
    if ({exc_valid, exc_cause, exc_pc} !== {1'b1, 3'd3, 6'd30}) begin
      errors++; $display("FAIL pending_load: got valid=%0b cause=%0d pc=%0d want 1/3/30", exc_valid, exc_cause, exc_pc);
    end
    checks++;
    if (exc_count !== 8'd4) begin errors++; $display("FAIL pending_count: got %0d want 4", exc_count); end
    tick();
    checks++;
    if ({pc_redirect, flush_ifid, flush_idex, flush_exmem, exc_valid} !== 5'b11101) begin
      errors++; $display("FAIL pending_reflush: got redirect/ifid/idex/exmem/valid=%b%b%b%b%b want 11101",
                         pc_redirect, flush_ifid, flush_idex, flush_exmem, exc_valid);
    end
    tick();
    pulse_ack();
    checks++;
    if (exc_valid !== 1'b0) begin errors++; $display("FAIL pending_drained: got valid=%0b want 0", exc_valid); end
  endtask

  task automatic test_mask_and_nop();
    cause_mask = 5'b11110;
    ifid_valid = 1'b1; opcode = 6'd2; ifid_pc = 6'd5;
    tick();
    tick();
    checks++;
    if (exc_valid !== 1'b0) begin errors++; $display("FAIL masked_opcode: got valid=%0b want 0", exc_valid); end
    clear_inputs();
    cause_mask = 5'b11111;
    ifid_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (exc_valid !== 1'b0 || exc_count !== 8'd4) begin
      errors++; $display("FAIL nop_legal: got valid=%0b count=%0d want 0/4", exc_valid, exc_count);
    end
    clear_inputs();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (exc_valid !== 1'b0 || exc_count !== 8'd4) begin
      errors++; $display("FAIL idle_ack: got valid=%0b count=%0d want 0/4", exc_valid, exc_count);
    end
  endtask

  task automatic test_irq_retrigger();
    irq = 1'b1; ifid_pc = 6'd40;
    tick();
    checks++;
    if ({exc_valid, exc_cause, exc_pc} !== {1'b1, 3'd5, 6'd40}) begin
      errors++; $display("FAIL irq_capture: got valid=%0b cause=%0d pc=%0d want 1/5/40", exc_valid, exc_cause, exc_pc);
    end
    tick();
    tick();
    tick();
    pulse_ack();
    checks++;
    if ({exc_valid, exc_cause, exc_pc, exc_count} !== {1'b1, 3'd5, 6'd40, 8'd6}) begin
      errors++; $display("FAIL irq_retrigger: got valid=%0b cause=%0d pc=%0d count=%0d want 1/5/40/6",
                         exc_valid, exc_cause, exc_pc, exc_count);
    end
    clear_inputs();
    tick();
    tick();
    pulse_ack();
    checks++;
    if (exc_valid !== 1'b0) begin errors++; $display("FAIL irq_release: got valid=%0b want 0", exc_valid); end
  endtask

  task automatic test_back_to_back();
    ifid_valid = 1'b1; opcode = 6'd2; ifid_pc = 6'd3;
    tick();
    clear_inputs();
    tick();
    tick();
    irq = 1'b1; ifid_pc = 6'd44;
    tick();
    clear_inputs();
    // ack and an overflow in the same cycle: overflow outranks the pending irq
    ack = 1'b1; idex_valid = 1'b1; ov = 1'b1; idex_pc = 6'd50;
    tick();
    clear_inputs();
    checks++;
    if ({exc_valid, exc_cause, exc_pc, exc_count} !== {1'b1, 3'd4, 6'd50, 8'd8}) begin
      errors++; $display("FAIL ack_preempt: got valid=%0b cause=%0d pc=%0d count=%0d want 1/4/50/8",
                         exc_valid, exc_cause, exc_pc, exc_count);
    end
    tick();
    tick();
    pulse_ack();
    checks++;
    if (exc_valid !== 1'b0) begin errors++; $display("FAIL preempt_loser_dropped: got valid=%0b want 0", exc_valid); end
  endtask

  task automatic test_reset_mid();
    ifid_valid = 1'b1; opcode = 6'd2; ifid_pc = 6'd7;
    tick();
    clear_inputs();
    tick();
    checks++;
    if (pc_redirect !== 1'b1) begin errors++; $display("FAIL pre_reset_redirect: got %0b want 1", pc_redirect); end
    rst = 1'b0;
    #1;
    checks++;
    if ({exc_valid, exc_cause, exc_pc, pc_redirect, flush_ifid, flush_idex, flush_exmem, exc_count} !== 22'd0) begin
      errors++; $display("FAIL async_reset: got valid=%0b cause=%0d pc=%0d redirect=%0b count=%0d want all 0",
                         exc_valid, exc_cause, exc_pc, pc_redirect, exc_count);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({exc_valid, pc_redirect} !== 2'b00) begin
        errors++; $display("FAIL post_reset_quiet[%0d]: got valid=%0b redirect=%0b want 0", i, exc_valid, pc_redirect);
      end
    end
  endtask

  task automatic test_saturate();
    int exp;
    for (int i = 0; i < 260; i++) begin
      idex_valid = 1'b1; ov = 1'b1; idex_pc = 6'(i);
      tick();
      clear_inputs();
      exp = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (exc_count !== 8'(exp)) begin
        errors++; $display("FAIL saturate[%0d]: got %0d want %0d", i, exc_count, exp);
      end
      tick();
      tick();
      pulse_ack();
    end
  endtask

  initial begin
    test_reset();
    test_opcode();
    test_overflow_vs_funct();
    test_pending();
    test_mask_and_nop();
    test_irq_retrigger();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
